// File: rtl/i2c_rr_ctrl_pkg.sv
// Shared types and constants for the round-robin i2c controller.
package i2c_ctrl_pkg;

  localparam int ADDR_W = 7;
  localparam int REG_W  = 8;
  localparam int DATA_W = 8;

  localparam logic I2C_RW_WRITE = 1'b1;
  localparam logic I2C_RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ctrl_state_e;

  // Fields handed to the engine; held for the whole transaction.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  sreg;
    logic [DATA_W-1:0] wdata;
  } i2c_cmd_t;

  // Width of a requester index; never zero, even for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_rr_ctrl_if.sv
// Client-side request/response bus plus engine-side control bus.
// master = controller view, slave = clients/engine view.
interface i2c_rr_ctrl_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]                             req;
  logic [N_REQ-1:0]                             req_rw;
  logic [N_REQ-1:0][i2c_ctrl_pkg::ADDR_W-1:0]   req_addr;
  logic [N_REQ-1:0][i2c_ctrl_pkg::REG_W-1:0]    req_reg;
  logic [N_REQ-1:0][i2c_ctrl_pkg::DATA_W-1:0]   req_wdata;

  logic [N_REQ-1:0]                             resp_valid;
  logic [i2c_ctrl_pkg::DATA_W-1:0]              resp_rdata;
  logic                                         resp_nack;
  logic                                         resp_timeout;
  logic                                         ctrl_busy;

  logic                                         i2c_start;
  logic                                         i2c_rw;
  logic [i2c_ctrl_pkg::ADDR_W-1:0]              i2c_slave_address;
  logic [i2c_ctrl_pkg::REG_W-1:0]               i2c_slave_reg;
  logic [i2c_ctrl_pkg::DATA_W-1:0]              i2c_tx_data;
  logic                                         i2c_done;
  logic                                         i2c_ack;
  logic [i2c_ctrl_pkg::DATA_W-1:0]              i2c_rx_data;

  modport master (
    input  req, req_rw, req_addr, req_reg, req_wdata,
    output resp_valid, resp_rdata, resp_nack, resp_timeout, ctrl_busy,
    output i2c_start, i2c_rw, i2c_slave_address, i2c_slave_reg, i2c_tx_data,
    input  i2c_done, i2c_ack, i2c_rx_data
  );

  modport slave (
    output req, req_rw, req_addr, req_reg, req_wdata,
    input  resp_valid, resp_rdata, resp_nack, resp_timeout, ctrl_busy,
    input  i2c_start, i2c_rw, i2c_slave_address, i2c_slave_reg, i2c_tx_data,
    output i2c_done, i2c_ack, i2c_rx_data
  );

endinterface

// File: rtl/i2c_rr_ctrl_rr_arbiter.sv
// Combinational round-robin search: first set req bit after ptr, wrapping.
module rr_arbiter
  import i2c_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW   = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);

  int pos;

  // Walk ptr+1 .. ptr+N_REQ (mod N_REQ); the first hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (en && !any && req[pos[IW-1:0]]) begin
        any               = 1'b1;
        idx               = pos[IW-1:0];
        gnt[pos[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_rr_ctrl.sv
// Round-robin controller sharing one i2c byte engine between N_REQ clients.
// Optional watchdog: define I2C_CTRL_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYC RUN cycles; otherwise RUN waits for i2c_done indefinitely.
module i2c_rr_ctrl
  import i2c_ctrl_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int TO_W        = 17
) (
  input  logic          clk,
  input  logic          reset_n,
  i2c_rr_ctrl_if.master bus
);

  localparam int IW = idx_w(N_REQ);

  // The watchdog counter must be able to reach TIMEOUT_CYC.
  if (longint'(TIMEOUT_CYC) >= (longint'(1) << TO_W)) begin : g_bad_to_w
    $error("TO_W too narrow for TIMEOUT_CYC");
  end

  ctrl_state_e          state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic [N_REQ-1:0]     goh_q, goh_d;
  i2c_cmd_t             cmd_q, cmd_d;
  logic                 busy_q, busy_d;
  logic                 start_q, start_d;
  logic                 ack_seen_q, ack_seen_d;
  logic                 first_q, first_d;
  logic [N_REQ-1:0]     rv_q, rv_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 nack_q, nack_d;
  logic                 to_hit;

  logic [N_REQ-1:0]     arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req (bus.req),
    .ptr (ptr_q),
    .en  (state_q == IDLE),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

`ifdef I2C_CTRL_TIMEOUT_EN
  logic [TO_W-1:0] wd_q, wd_d;
  logic            tout_q, tout_d;

  assign to_hit = (wd_q == TO_W'(TIMEOUT_CYC - 1));

  // Watchdog counts RUN cycles; cleared in LOAD, flag lives for the DONE cycle.
  always_comb begin
    wd_d   = wd_q;
    tout_d = 1'b0;
    if (state_q == LOAD) wd_d = '0;
    else if (state_q == RUN) begin
      wd_d = wd_q + 1'b1;
      if ((first_q || !bus.i2c_done) && to_hit) tout_d = 1'b1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wd_q   <= '0;
      tout_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      tout_q <= tout_d;
    end
  end

  assign bus.resp_timeout = tout_q;
`else
  assign to_hit           = 1'b0;
  assign bus.resp_timeout = 1'b0;
`endif

  // Next-state and next-output logic; all outputs are registered.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    goh_d      = goh_q;
    cmd_d      = cmd_q;
    busy_d     = busy_q;
    ack_seen_d = ack_seen_q;
    first_d    = first_q;
    rv_d       = '0;
    rdata_d    = '0;
    nack_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gidx_d      = arb_idx;
          goh_d       = arb_gnt;
          cmd_d.rw    = bus.req_rw[arb_idx];
          cmd_d.addr  = bus.req_addr[arb_idx];
          cmd_d.sreg  = bus.req_reg[arb_idx];
          cmd_d.wdata = bus.req_wdata[arb_idx];
          busy_d      = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        ack_seen_d = 1'b0;
        first_d    = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        first_d = 1'b0;
        if (bus.i2c_ack) ack_seen_d = 1'b1;
        // done seen on the first RUN cycle may be left over from the last job
        if (!first_q && bus.i2c_done) begin
          state_d = DONE;
          busy_d  = 1'b0;
          rv_d    = goh_q;
          rdata_d = (cmd_q.rw == I2C_RW_READ) ? bus.i2c_rx_data : '0;
          nack_d  = !(ack_seen_q || bus.i2c_ack);
        end else if (to_hit) begin
          state_d = DONE;
          busy_d  = 1'b0;
          rv_d    = goh_q;
          nack_d  = 1'b1;
        end
      end
      DONE: begin
        ptr_d   = gidx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    start_d = (state_d != RUN);
  end

  // State and output registers; reset parks the engine and drops any job.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= IW'(N_REQ - 1);
      gidx_q     <= '0;
      goh_q      <= '0;
      cmd_q      <= '0;
      busy_q     <= 1'b0;
      start_q    <= 1'b1;
      ack_seen_q <= 1'b0;
      first_q    <= 1'b0;
      rv_q       <= '0;
      rdata_q    <= '0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      goh_q      <= goh_d;
      cmd_q      <= cmd_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      ack_seen_q <= ack_seen_d;
      first_q    <= first_d;
      rv_q       <= rv_d;
      rdata_q    <= rdata_d;
      nack_q     <= nack_d;
    end
  end

  assign bus.resp_valid        = rv_q;
  assign bus.resp_rdata        = rdata_q;
  assign bus.resp_nack         = nack_q;
  assign bus.ctrl_busy         = busy_q;
  assign bus.i2c_start         = start_q;
  assign bus.i2c_rw            = cmd_q.rw;
  assign bus.i2c_slave_address = cmd_q.addr;
  assign bus.i2c_slave_reg     = cmd_q.sreg;
  assign bus.i2c_tx_data       = cmd_q.wdata;

endmodule

// File: doc/i2c_rr_ctrl.md
Name: i2c_rr_ctrl

Overview:
Round-robin controller that shares one i2c byte-transaction engine between N_REQ requesters (e.g. sensor config, codec config, CPU bridge).
- Arbitrates pending requests.
- Loads the winner's address, register, data and direction into the engine.
- Sequences the engine's start/done handshake.
- Returns read data and status to the winner.
- Sits between the engine and the wishbone-side/config-side clients.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT_CYC, 100000, watchdog limit in clk cycles per transaction (one full read takes about 42000 cycles)
TO_W, 17, watchdog counter width; must satisfy 2^TO_W > TIMEOUT_CYC

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active-low
req  in  N_REQ  per-requester request level; held until matching resp_valid
req_rw  in  N_REQ  1 = write, 0 = read (engine convention)
req_addr  in  7*N_REQ  7-bit slave address per requester
req_reg  in  8*N_REQ  slave register per requester
req_wdata  in  8*N_REQ  write byte per requester
resp_valid  out  N_REQ  one-hot, one-cycle completion pulse
resp_rdata  out  8  read byte; valid with resp_valid
resp_nack  out  1  no ack seen during transaction; valid with resp_valid
resp_timeout  out  1  watchdog expiry; valid with resp_valid
ctrl_busy  out  1  high from grant until resp_valid
i2c_start  out  1  engine start/park level
i2c_rw  out  1  to engine
i2c_slave_address  out  7  to engine
i2c_slave_reg  out  8  to engine
i2c_tx_data  out  8  to engine
i2c_done  in  1  engine finish level; stays high until start reasserts
i2c_ack  in  1  engine ack indication; may be a single-cycle pulse
i2c_rx_data  in  8  engine read byte

Behaviour:
- Reset (reset_n low at a clk edge):
  - state = IDLE, i2c_start = 1 (engine parked).
  - All other outputs = 0.
  - rr pointer = N_REQ-1, so requester 0 wins first.
  - Reset mid-transaction abandons it: no resp_valid, engine is parked.
- Engine contract:
  - Engine is idle while i2c_start = 1.
  - Engine runs while i2c_start = 0.
  - The engine's rw, address, register and data inputs are held stable for the whole transaction.
- FSM:
  - IDLE: i2c_start = 1. If any req bit is set, grant the first set bit searching from pointer+1 with wrap-around. Register the grant index, latch that requester's fields into the engine output registers, set ctrl_busy = 1, go to LOAD. Only one grant per cycle.
  - LOAD: one cycle with i2c_start = 1 and fields stable. Clear ack_seen and the watchdog. Go to RUN.
  - RUN: i2c_start = 0.
    - First RUN cycle ignores i2c_done, which may be stale from the previous transaction.
    - Any cycle with i2c_ack = 1 sets sticky ack_seen.
    - From the second RUN cycle, i2c_done = 1 moves to DONE.
  - DONE: i2c_start = 1 (park).
    - resp_valid[grant] = 1 for exactly this cycle.
    - resp_rdata = i2c_rx_data for reads, 0 for writes.
    - resp_nack = !ack_seen.
    - ctrl_busy = 0. Pointer = grant. Go to IDLE.
- Timing:
  - Minimum gap from resp_valid to the next grant is 1 cycle (DONE→IDLE→grant).
  - Latency from a request in an idle controller to i2c_start falling is 2 cycles.
- Fairness: a requester holding req continuously is served within N_REQ transactions.
- Boundary conditions:
  - A req drop while that requester is granted is ignored; the transaction completes and the pulse is still issued.
  - A req bit that is still high on the cycle after its own resp_valid is a new request.
  - All req bits set simultaneously: grants go 0,1,2,3,0,…
  - i2c_done asserted in LOAD is ignored.

Optional Feature:
I2C_CTRL_TIMEOUT_EN
- Defined: a TO_W-bit watchdog counts RUN cycles. Reaching TIMEOUT_CYC forces DONE with resp_timeout = 1, resp_nack = 1, resp_rdata = 0. The engine is parked via i2c_start = 1, which returns it to stage 0.
- Undefined: no counter; resp_timeout is tied to 0; RUN waits indefinitely for i2c_done.

Decomposition:
- Package i2c_ctrl_pkg:
  - state encoding (IDLE, LOAD, RUN, DONE; 2 bits)
  - I2C_RW_WRITE = 1, I2C_RW_READ = 0
  - address, register and data widths (7, 8, 8)
- Sub-module rr_arbiter (parameter N_REQ):
  - inputs: req vector, pointer, enable
  - outputs: one-hot grant, binary index, any
  - purely combinational search; the controller holds the registers.

Test Plan:
1. Single write: req[0], rw = 1, addr = 7'h21, reg = 8'h0A, wdata = 8'h5C. Engine model acks. Expect i2c_start low for the whole transaction with fields stable, then resp_valid = 4'b0001, resp_nack = 0, resp_rdata = 0.
2. Single read: req[2], rw = 0, addr = 7'h48, reg = 8'h00. Model returns 8'hA7 with an ack pulse. Expect resp_valid = 4'b0100, resp_rdata = 8'hA7, nack = 0.
3. Round-robin: all four req held. Expect completion order 0,1,2,3,0, and the pointer wraps after 3.
4. NACK: model never pulses i2c_ack. Expect resp_nack = 1 and the controller returns to IDLE.
5. Stale done: model holds i2c_done = 1 into the next transaction's first RUN cycle. Expect no premature resp_valid.
6. Reset and timeout:
   - reset_n low for 1 cycle mid-RUN: expect i2c_start = 1 and outputs 0 next cycle, no resp_valid.
   - With I2C_CTRL_TIMEOUT_EN and TIMEOUT_CYC = 50 and done never asserted: expect resp_timeout = 1 exactly 50 RUN cycles after entry.
